// File: rtl/fifo_fwft_read_adapter.sv
// FIFO first-word-fall-through read adapter.
// Turns an upstream FIFO with one-cycle read latency into a registered
// valid/ready stream. A two-entry in-order buffer plus a pending-read flag
// lets the adapter keep issuing reads while downstream stalls. The sum of
// occupancy and pending reads is bounded by two, so a captured word always
// has a free slot.
module fifo_fwft_read_adapter #(
    parameter int G_W = 72
) (
    input  logic           i_clk,
    input  logic           i_arst,
    input  logic           i_fifo_empt,
    output logic           o_fifo_rena,
    input  logic [G_W-1:0] i_fifo_rdat,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [G_W-1:0] o_data,
    output logic [1:0]     o_occ
);

    logic [G_W-1:0] entry0;
    logic [G_W-1:0] entry1;
    logic [1:0]     occ;
    logic           pend;

    logic           pop;
    logic [1:0]     occ_after_pop;
    logic [2:0]     demand;

    assign pop = (occ != 2'd0) && i_ready;

    // Occupancy after this edge's pop and the slot demand including the in-flight read.
    always_comb begin
        occ_after_pop = occ - {1'b0, pop};
        demand        = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    end

    // Only read when the word it returns is guaranteed a free buffer slot.
    assign o_fifo_rena = ~i_fifo_empt & ~i_arst & (demand < 3'd2);

    // Occupancy and pending-read bookkeeping.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            occ  <= 2'd0;
            pend <= 1'b0;
        end else begin
            pend <= o_fifo_rena;
            occ  <= occ_after_pop + {1'b0, pend};
        end
    end

    // Head entry: captures returning data into an empty head, or takes entry1
    // when the head is consumed with a second word behind it; otherwise holds
    // so the last head value stays visible when the buffer drains.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            entry0 <= '0;
        end else if (pend && (occ_after_pop == 2'd0)) begin
            entry0 <= i_fifo_rdat;
        end else if (pop && (occ == 2'd2)) begin
            entry0 <= entry1;
        end
    end

    // Second entry: captures returning data when the head remains occupied.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            entry1 <= '0;
        end else if (pend && (occ_after_pop == 2'd1)) begin
            entry1 <= i_fifo_rdat;
        end
    end

    assign o_valid = (occ != 2'd0);
    assign o_data  = entry0;
    assign o_occ   = occ;

endmodule
